// File: rtl/bp_fe_lce_cmd_engine_pkg.sv
// Shared types for the icache LCE command engine.
// Holds the fixed processor configuration used by this slice (ids, address
// split, icache geometry), the CCE->LCE command and LCE->CCE response
// encodings, the icache tag/data mem opcodes, and the packet structs that
// travel between the command engine, the icache and the coherence network.
package bp_fe_lce_cmd_engine_pkg;

  localparam int lce_id_width_gp       = 2;
  localparam int cce_id_width_gp       = 3;
  localparam int paddr_width_gp        = 32;
  localparam int icache_sets_gp        = 64;
  localparam int icache_assoc_gp       = 8;
  localparam int block_width_gp        = 128;
  localparam int index_width_gp        = $clog2(icache_sets_gp);
  localparam int way_width_gp          = $clog2(icache_assoc_gp);
  localparam int block_offset_width_gp = $clog2(block_width_gp / 8);
  localparam int tag_width_gp          = paddr_width_gp - index_width_gp - block_offset_width_gp;
  localparam int coh_state_width_gp    = 2;

  typedef enum logic [3:0] {
    e_lce_cmd_sync           = 4'd0,
    e_lce_cmd_set_clear      = 4'd1,
    e_lce_cmd_transfer       = 4'd2,
    e_lce_cmd_writeback      = 4'd3,
    e_lce_cmd_set_tag        = 4'd4,
    e_lce_cmd_set_tag_wakeup = 4'd5,
    e_lce_cmd_invalidate_tag = 4'd6,
    e_lce_cmd_uc_st_done     = 4'd7,
    e_lce_cmd_data           = 4'd8,
    e_lce_cmd_uc_data        = 4'd9
  } bp_lce_cmd_type_e;

  typedef enum logic [1:0] {
    e_lce_cce_sync_ack = 2'd0,
    e_lce_cce_inv_ack  = 2'd1,
    e_lce_cce_coh_ack  = 2'd2,
    e_lce_cce_resp_wb  = 2'd3
  } bp_lce_cce_resp_type_e;

  typedef enum logic [1:0] {
    e_tag_mem_clear      = 2'd0,
    e_tag_mem_set_tag    = 2'd1,
    e_tag_mem_invalidate = 2'd2,
    e_tag_mem_set_state  = 2'd3
  } bp_icache_tag_mem_opcode_e;

  typedef enum logic [0:0] {
    e_data_mem_write    = 1'b0,
    e_data_mem_uncached = 1'b1
  } bp_icache_data_mem_opcode_e;

  typedef struct packed {
    bp_lce_cmd_type_e                msg_type;
    logic [way_width_gp-1:0]         way_id;
    logic [coh_state_width_gp-1:0]   state;
    logic [paddr_width_gp-1:0]       addr;
    logic [block_width_gp-1:0]       data;
  } bp_lce_cmd_s;

  typedef struct packed {
    logic [index_width_gp-1:0]       index;
    logic [way_width_gp-1:0]         way;
    bp_icache_tag_mem_opcode_e       opcode;
    logic [tag_width_gp-1:0]         tag;
    logic [coh_state_width_gp-1:0]   state;
  } bp_icache_tag_mem_pkt_s;

  typedef struct packed {
    logic [index_width_gp-1:0]       index;
    logic [way_width_gp-1:0]         way;
    bp_icache_data_mem_opcode_e      opcode;
    logic [block_width_gp-1:0]       data;
  } bp_icache_data_mem_pkt_s;

  typedef struct packed {
    logic [cce_id_width_gp-1:0]      dst_id;
    logic [lce_id_width_gp-1:0]      src_id;
    bp_lce_cce_resp_type_e           msg_type;
    logic [paddr_width_gp-1:0]       addr;
  } bp_lce_cce_resp_s;

  localparam int cmd_width_gp  = $bits(bp_lce_cmd_s);
  localparam int tpkt_width_gp = $bits(bp_icache_tag_mem_pkt_s);
  localparam int dpkt_width_gp = $bits(bp_icache_data_mem_pkt_s);
  localparam int resp_width_gp = $bits(bp_lce_cce_resp_s);

endpackage

// File: rtl/bp_fe_lce_cmd_engine_cce_id.sv
// Maps a block address to its home CCE.
// Blocks are interleaved across the CCEs at block granularity, so the home
// CCE is the block number modulo the CCE count.
//  blk_addr_i  in   block number (paddr without the block offset)
//  cce_id_o    out  home CCE id
module bp_fe_lce_cmd_engine_cce_id
  import bp_fe_lce_cmd_engine_pkg::*;
#(
  parameter int num_cce_p = 1
) (
  input  logic [paddr_width_gp-block_offset_width_gp-1:0] blk_addr_i,
  output logic [cce_id_width_gp-1:0]                      cce_id_o
);

  assign cce_id_o = cce_id_width_gp'(32'(blk_addr_i) % 32'(num_cce_p));

endmodule

// File: rtl/bp_fe_lce_cmd_engine.sv
// Icache-side LCE command engine.
// Consumes CCE->LCE commands, turns them into icache tag/data mem write
// packets, returns sync/invalidate acks, and pulses the *_received strobes
// that wake the icache LCE request FSM.
//  clk_i / reset_i                      clock, asynchronous active-high reset
//  lce_id_i                             own LCE id (resp src_id)
//  lce_cmd_i / _v_i / _yumi_o           command in; yumi once per command on completion
//  tag_mem_pkt_o / _v_o / _yumi_i       tag mem write packet
//  data_mem_pkt_o / _v_o / _yumi_i      data mem write packet
//  lce_resp_o / _v_o / _ready_i         sync_ack / inv_ack to the CCE
//  *_received_o                         one-cycle completion strobes
//  coherence_blocked_o                  command pending, a mem packet was refused
//  cmd_ready_o                          idle with no command pending
//  sync_done_o                          every CCE has been sync-acked (sticky)
module bp_fe_lce_cmd_engine
  import bp_fe_lce_cmd_engine_pkg::*;
#(
  parameter  int num_cce_p     = 1,
  localparam int sync_width_lp = $clog2(num_cce_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [lce_id_width_gp-1:0] lce_id_i,
  input  logic [cmd_width_gp-1:0]    lce_cmd_i,
  input  logic                       lce_cmd_v_i,
  output logic                       lce_cmd_yumi_o,
  output logic [tpkt_width_gp-1:0]   tag_mem_pkt_o,
  output logic                       tag_mem_pkt_v_o,
  input  logic                       tag_mem_pkt_yumi_i,
  output logic [dpkt_width_gp-1:0]   data_mem_pkt_o,
  output logic                       data_mem_pkt_v_o,
  input  logic                       data_mem_pkt_yumi_i,
  output logic [resp_width_gp-1:0]   lce_resp_o,
  output logic                       lce_resp_v_o,
  input  logic                       lce_resp_ready_i,
  output logic                       cce_data_received_o,
  output logic                       uncached_data_received_o,
  output logic                       set_tag_received_o,
  output logic                       set_tag_wakeup_received_o,
  output logic                       coherence_blocked_o,
  output logic                       cmd_ready_o,
  output logic                       sync_done_o
);

  localparam logic [0:0] e_ready     = 1'b0;
  localparam logic [0:0] e_send_resp = 1'b1;

  bp_lce_cmd_s             cmd;
  bp_icache_tag_mem_pkt_s  tag_pkt;
  bp_icache_data_mem_pkt_s data_pkt;
  bp_lce_cce_resp_s        resp;

  logic [0:0]                 state_r, state_n;
  bp_lce_cce_resp_type_e      resp_type_r, resp_type_n;
  logic [sync_width_lp-1:0]   sync_cnt_r;
  logic                       sync_inc;
  logic                       tag_done_r, tag_done_n;
  logic                       data_done_r, data_done_n;
  logic                       tag_ok, data_ok;
  logic [cce_id_width_gp-1:0] dst_cce_id;
  logic [index_width_gp-1:0]  cmd_index;
  logic [tag_width_gp-1:0]    cmd_tag;

  assign cmd       = lce_cmd_i;
  assign cmd_index = cmd.addr[block_offset_width_gp +: index_width_gp];
  assign cmd_tag   = cmd.addr[paddr_width_gp-1 -: tag_width_gp];
  // A mem packet counts as done once accepted, either in an earlier cycle or now.
  assign tag_ok    = tag_done_r | tag_mem_pkt_yumi_i;
  assign data_ok   = data_done_r | data_mem_pkt_yumi_i;

  bp_fe_lce_cmd_engine_cce_id #(
    .num_cce_p(num_cce_p)
  ) cce_id (
    .blk_addr_i(cmd.addr[paddr_width_gp-1:block_offset_width_gp]),
    .cce_id_o  (dst_cce_id)
  );

  always_comb begin
    state_n                   = state_r;
    resp_type_n               = resp_type_r;
    tag_done_n                = tag_done_r;
    data_done_n               = data_done_r;
    sync_inc                  = 1'b0;
    tag_mem_pkt_v_o           = 1'b0;
    data_mem_pkt_v_o          = 1'b0;
    lce_resp_v_o              = 1'b0;
    lce_cmd_yumi_o            = 1'b0;
    cce_data_received_o       = 1'b0;
    uncached_data_received_o  = 1'b0;
    set_tag_received_o        = 1'b0;
    set_tag_wakeup_received_o = 1'b0;
    tag_pkt  = '{index: cmd_index, way: cmd.way_id, opcode: e_tag_mem_set_tag,
                 tag: cmd_tag, state: cmd.state};
    data_pkt = '{index: cmd_index, way: cmd.way_id, opcode: e_data_mem_write,
                 data: cmd.data};

    if (state_r == e_ready) begin
      if (lce_cmd_v_i) begin
        case (cmd.msg_type)
          e_lce_cmd_sync: begin
            resp_type_n = e_lce_cce_sync_ack;
            state_n     = e_send_resp;
          end
          e_lce_cmd_set_clear: begin
            // Clear opcode wipes every way of the set; the way field is ignored.
            tag_pkt.opcode  = e_tag_mem_clear;
            tag_mem_pkt_v_o = 1'b1;
            lce_cmd_yumi_o  = tag_mem_pkt_yumi_i;
          end
          e_lce_cmd_invalidate_tag: begin
            tag_pkt.opcode  = e_tag_mem_invalidate;
            tag_mem_pkt_v_o = 1'b1;
            if (tag_mem_pkt_yumi_i) begin
              resp_type_n = e_lce_cce_inv_ack;
              state_n     = e_send_resp;
            end
          end
          e_lce_cmd_set_tag, e_lce_cmd_set_tag_wakeup: begin
            tag_mem_pkt_v_o = 1'b1;
            if (tag_mem_pkt_yumi_i) begin
              lce_cmd_yumi_o            = 1'b1;
              set_tag_received_o        = (cmd.msg_type == e_lce_cmd_set_tag);
              set_tag_wakeup_received_o = (cmd.msg_type == e_lce_cmd_set_tag_wakeup);
            end
          end
          e_lce_cmd_data: begin
            // Tag and data writes may be accepted in any order; each packet
            // drops out once its own accept has been recorded.
            tag_mem_pkt_v_o  = ~tag_done_r;
            data_mem_pkt_v_o = ~data_done_r;
            if (tag_ok & data_ok) begin
              lce_cmd_yumi_o      = 1'b1;
              cce_data_received_o = 1'b1;
              set_tag_received_o  = 1'b1;
              tag_done_n          = 1'b0;
              data_done_n         = 1'b0;
            end else begin
              tag_done_n  = tag_ok;
              data_done_n = data_ok;
            end
          end
          e_lce_cmd_uc_data: begin
            data_pkt.opcode  = e_data_mem_uncached;
            data_pkt.data    = {{(block_width_gp-64){1'b0}}, cmd.data[63:0]};
            data_mem_pkt_v_o = 1'b1;
            if (data_mem_pkt_yumi_i) begin
              lce_cmd_yumi_o           = 1'b1;
              uncached_data_received_o = 1'b1;
            end
          end
          default: lce_cmd_yumi_o = 1'b1;
        endcase
      end
    end else begin
      lce_resp_v_o = 1'b1;
      if (lce_resp_ready_i) begin
        lce_cmd_yumi_o = 1'b1;
        sync_inc       = (resp_type_r == e_lce_cce_sync_ack);
        state_n        = e_ready;
      end
    end
  end

  assign resp = '{dst_id: dst_cce_id, src_id: lce_id_i, msg_type: resp_type_r,
                  addr: cmd.addr};

  assign tag_mem_pkt_o       = tag_pkt;
  assign data_mem_pkt_o      = data_pkt;
  assign lce_resp_o          = resp;
  assign coherence_blocked_o = (state_r == e_ready) & lce_cmd_v_i
                             & ((tag_mem_pkt_v_o & ~tag_mem_pkt_yumi_i)
                              | (data_mem_pkt_v_o & ~data_mem_pkt_yumi_i));
  assign cmd_ready_o         = (state_r == e_ready) & ~lce_cmd_v_i;
  assign sync_done_o         = (sync_cnt_r == sync_width_lp'(num_cce_p));

  // Registered control state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_ready;
      resp_type_r <= e_lce_cce_sync_ack;
      sync_cnt_r  <= '0;
      tag_done_r  <= 1'b0;
      data_done_r <= 1'b0;
    end else begin
      state_r     <= state_n;
      resp_type_r <= resp_type_n;
      tag_done_r  <= tag_done_n;
      data_done_r <= data_done_n;
      if (sync_inc && !sync_done_o)
        sync_cnt_r <= sync_cnt_r + sync_width_lp'(1);
    end
  end

endmodule

// File: tb/tb_bp_fe_lce_cmd_engine.sv
// Directed bench for bp_fe_lce_cmd_engine (num_cce_p = 1).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_bp_fe_lce_cmd_engine;
  import bp_fe_lce_cmd_engine_pkg::*;

  // Bit positions of the packed control/status view "ctl".
  localparam logic [10:0] C_YUMI  = 11'h400;
  localparam logic [10:0] C_TAGV  = 11'h200;
  localparam logic [10:0] C_DATAV = 11'h100;
  localparam logic [10:0] C_RESPV = 11'h080;
  localparam logic [10:0] C_CDR   = 11'h040;
  localparam logic [10:0] C_UDR   = 11'h020;
  localparam logic [10:0] C_STR   = 11'h010;
  localparam logic [10:0] C_STWR  = 11'h008;
  localparam logic [10:0] C_BLK   = 11'h004;
  localparam logic [10:0] C_READY = 11'h002;
  localparam logic [10:0] C_DONE  = 11'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       reset_i;
  logic [lce_id_width_gp-1:0] lce_id;
  bp_lce_cmd_s                cmd;
  logic                       cmd_v, cmd_yumi;
  bp_icache_tag_mem_pkt_s     tag_pkt;
  logic                       tag_v, tag_yumi;
  bp_icache_data_mem_pkt_s    data_pkt;
  logic                       data_v, data_yumi;
  bp_lce_cce_resp_s           resp;
  logic                       resp_v, resp_ready;
  logic                       cdr, udr, str, stwr, blocked, cmd_ready, sync_done;
  logic [10:0]                ctl;

  int n_cmp  = 0;
  int n_fail = 0;

  assign ctl = {cmd_yumi, tag_v, data_v, resp_v, cdr, udr, str, stwr, blocked, cmd_ready, sync_done};

  bp_fe_lce_cmd_engine #(.num_cce_p(1)) dut (
    .clk_i                    (clk),
    .reset_i                  (reset_i),
    .lce_id_i                 (lce_id),
    .lce_cmd_i                (cmd),
    .lce_cmd_v_i              (cmd_v),
    .lce_cmd_yumi_o           (cmd_yumi),
    .tag_mem_pkt_o            (tag_pkt),
    .tag_mem_pkt_v_o          (tag_v),
    .tag_mem_pkt_yumi_i       (tag_yumi),
    .data_mem_pkt_o           (data_pkt),
    .data_mem_pkt_v_o         (data_v),
    .data_mem_pkt_yumi_i      (data_yumi),
    .lce_resp_o               (resp),
    .lce_resp_v_o             (resp_v),
    .lce_resp_ready_i         (resp_ready),
    .cce_data_received_o      (cdr),
    .uncached_data_received_o (udr),
    .set_tag_received_o       (str),
    .set_tag_wakeup_received_o(stwr),
    .coherence_blocked_o      (blocked),
    .cmd_ready_o              (cmd_ready),
    .sync_done_o              (sync_done)
  );

  function automatic bp_lce_cmd_s mk_cmd(input bp_lce_cmd_type_e t, input logic [2:0] way,
                                         input logic [1:0] st, input logic [31:0] addr,
                                         input logic [127:0] data);
    bp_lce_cmd_s c;
    c.msg_type = t;
    c.way_id   = way;
    c.state    = st;
    c.addr     = addr;
    c.data     = data;
    return c;
  endfunction

  task automatic test_reset;
    reset_i = 1'b1; cmd_v = 1'b0; tag_yumi = 1'b0; data_yumi = 1'b0; resp_ready = 1'b0;
    lce_id = 2'd1; cmd = '0;
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_READY) begin
      $display("FAIL reset_ctl: got %h want %h", ctl, C_READY); n_fail++;
    end
    @(negedge clk); #1;
    n_cmp++;
    if (ctl !== C_READY) begin
      $display("FAIL reset_idle_ctl: got %h want %h", ctl, C_READY); n_fail++;
    end
  endtask

  task automatic test_sync;
    bp_lce_cce_resp_s exp_resp;
    @(negedge clk);
    cmd = mk_cmd(e_lce_cmd_sync, 3'd0, 2'd0, 32'h0, '0); cmd_v = 1'b1; resp_ready = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== 11'h000) begin
      $display("FAIL sync_decode: got %h want %h", ctl, 11'h000); n_fail++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if (ctl !== C_RESPV) begin
        $display("FAIL sync_stall%0d: got %h want %h", i, ctl, C_RESPV); n_fail++;
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== (C_YUMI | C_RESPV)) begin
      $display("FAIL sync_accept: got %h want %h", ctl, C_YUMI | C_RESPV); n_fail++;
    end
    exp_resp = '{dst_id: 3'd0, src_id: 2'd1, msg_type: e_lce_cce_sync_ack, addr: 32'h0};
    n_cmp++;
    if (resp !== exp_resp) begin
      $display("FAIL sync_resp: got %h want %h", resp, exp_resp); n_fail++;
    end
    @(negedge clk);
    cmd_v = 1'b0; resp_ready = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== (C_READY | C_DONE)) begin
      $display("FAIL sync_done: got %h want %h", ctl, C_READY | C_DONE); n_fail++;
    end
  endtask

  task automatic test_data;
    bp_icache_tag_mem_pkt_s  exp_tag;
    bp_icache_data_mem_pkt_s exp_data;
    logic [127:0] d = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    @(negedge clk);
    cmd = mk_cmd(e_lce_cmd_data, 3'd2, 2'd2, {22'h2ABCD, 6'd5, 4'h0}, d);
    cmd_v = 1'b1; tag_yumi = 1'b1; data_yumi = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== (C_TAGV | C_DATAV | C_BLK | C_DONE)) begin
      $display("FAIL data_c1: got %h want %h", ctl, C_TAGV | C_DATAV | C_BLK | C_DONE); n_fail++;
    end
    exp_tag  = '{index: 6'd5, way: 3'd2, opcode: e_tag_mem_set_tag, tag: 22'h2ABCD, state: 2'd2};
    exp_data = '{index: 6'd5, way: 3'd2, opcode: e_data_mem_write, data: d};
    n_cmp++;
    if (tag_pkt !== exp_tag) begin
      $display("FAIL data_tag_pkt: got %h want %h", tag_pkt, exp_tag); n_fail++;
    end
    n_cmp++;
    if (data_pkt !== exp_data) begin
      $display("FAIL data_data_pkt: got %h want %h", data_pkt, exp_data); n_fail++;
    end
    @(negedge clk);
    tag_yumi = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== (C_DATAV | C_BLK | C_DONE)) begin
      $display("FAIL data_c2: got %h want %h", ctl, C_DATAV | C_BLK | C_DONE); n_fail++;
    end
    @(negedge clk);
    data_yumi = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== (C_YUMI | C_DATAV | C_CDR | C_STR | C_DONE)) begin
      $display("FAIL data_c3: got %h want %h", ctl, C_YUMI | C_DATAV | C_CDR | C_STR | C_DONE); n_fail++;
    end
    @(negedge clk);
    cmd_v = 1'b0; data_yumi = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== (C_READY | C_DONE)) begin
      $display("FAIL data_idle: got %h want %h", ctl, C_READY | C_DONE); n_fail++;
    end
  endtask

  task automatic test_wakeup;
    bp_icache_tag_mem_pkt_s exp_tag;
    @(negedge clk);
    cmd = mk_cmd(e_lce_cmd_set_tag_wakeup, 3'd7, 2'd1, {22'h15555, 6'd9, 4'h0}, '0);
    cmd_v = 1'b1; tag_yumi = 1'b0;
    #1;
    exp_tag = '{index: 6'd9, way: 3'd7, opcode: e_tag_mem_set_tag, tag: 22'h15555, state: 2'd1};
    n_cmp++;
    if (tag_pkt !== exp_tag) begin
      $display("FAIL wake_tag_pkt: got %h want %h", tag_pkt, exp_tag); n_fail++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i != 0) begin @(negedge clk); #1; end
      n_cmp++;
      if (ctl !== (C_TAGV | C_BLK | C_DONE)) begin
        $display("FAIL wake_stall%0d: got %h want %h", i, ctl, C_TAGV | C_BLK | C_DONE); n_fail++;
      end
    end
    @(negedge clk);
    tag_yumi = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== (C_YUMI | C_TAGV | C_STWR | C_DONE)) begin
      $display("FAIL wake_accept: got %h want %h", ctl, C_YUMI | C_TAGV | C_STWR | C_DONE); n_fail++;
    end
    @(negedge clk);
    cmd_v = 1'b0; tag_yumi = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== (C_READY | C_DONE)) begin
      $display("FAIL wake_idle: got %h want %h", ctl, C_READY | C_DONE); n_fail++;
    end
  endtask

  task automatic test_uc_data;
    bp_icache_data_mem_pkt_s exp_data;
    @(negedge clk);
    cmd = mk_cmd(e_lce_cmd_uc_data, 3'd4, 2'd0, {22'h00ABC, 6'd33, 4'h8},
                 {64'h1234_5678_9ABC_DEF0, 64'hDEADBEEF_CAFEF00D});
    cmd_v = 1'b1; data_yumi = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== (C_DATAV | C_BLK | C_DONE)) begin
      $display("FAIL uc_c1: got %h want %h", ctl, C_DATAV | C_BLK | C_DONE); n_fail++;
    end
    exp_data = '{index: 6'd33, way: 3'd4, opcode: e_data_mem_uncached,
                 data: {64'h0, 64'hDEADBEEF_CAFEF00D}};
    n_cmp++;
    if (data_pkt !== exp_data) begin
      $display("FAIL uc_data_pkt: got %h want %h", data_pkt, exp_data); n_fail++;
    end
    @(negedge clk);
    data_yumi = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== (C_YUMI | C_DATAV | C_UDR | C_DONE)) begin
      $display("FAIL uc_accept: got %h want %h", ctl, C_YUMI | C_DATAV | C_UDR | C_DONE); n_fail++;
    end
    @(negedge clk);
    cmd_v = 1'b0; data_yumi = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== (C_READY | C_DONE)) begin
      $display("FAIL uc_idle: got %h want %h", ctl, C_READY | C_DONE); n_fail++;
    end
  endtask

  task automatic test_back_to_back;
    bp_lce_cce_resp_s exp_resp;
    @(negedge clk);
    cmd = mk_cmd(e_lce_cmd_invalidate_tag, 3'd3, 2'd0, {22'h3FFFF, 6'd63, 4'h0}, '0);
    cmd_v = 1'b1; tag_yumi = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== (C_TAGV | C_DONE)) begin
      $display("FAIL inv_tag: got %h want %h", ctl, C_TAGV | C_DONE); n_fail++;
    end
    n_cmp++;
    if (tag_pkt.opcode !== e_tag_mem_invalidate) begin
      $display("FAIL inv_opcode: got %h want %h", tag_pkt.opcode, e_tag_mem_invalidate); n_fail++;
    end
    @(negedge clk);
    tag_yumi = 1'b0; resp_ready = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== (C_YUMI | C_RESPV | C_DONE)) begin
      $display("FAIL inv_resp_ctl: got %h want %h", ctl, C_YUMI | C_RESPV | C_DONE); n_fail++;
    end
    exp_resp = '{dst_id: 3'd0, src_id: 2'd1, msg_type: e_lce_cce_inv_ack,
                 addr: {22'h3FFFF, 6'd63, 4'h0}};
    n_cmp++;
    if (resp !== exp_resp) begin
      $display("FAIL inv_resp: got %h want %h", resp, exp_resp); n_fail++;
    end
    @(negedge clk);
    cmd = mk_cmd(e_lce_cmd_writeback, 3'd0, 2'd0, 32'h100, '0); resp_ready = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== (C_YUMI | C_DONE)) begin
      $display("FAIL other_yumi: got %h want %h", ctl, C_YUMI | C_DONE); n_fail++;
    end
    @(negedge clk);
    cmd = mk_cmd(e_lce_cmd_set_clear, 3'd5, 2'd0, {22'h0, 6'd12, 4'h0}, '0); tag_yumi = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== (C_YUMI | C_TAGV | C_DONE)) begin
      $display("FAIL clear_ctl: got %h want %h", ctl, C_YUMI | C_TAGV | C_DONE); n_fail++;
    end
    n_cmp++;
    if (tag_pkt.opcode !== e_tag_mem_clear || tag_pkt.index !== 6'd12) begin
      $display("FAIL clear_pkt: got %h want opcode %h index %h", tag_pkt, e_tag_mem_clear, 6'd12);
      n_fail++;
    end
    @(negedge clk);
    cmd_v = 1'b0; tag_yumi = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== (C_READY | C_DONE)) begin
      $display("FAIL b2b_idle: got %h want %h", ctl, C_READY | C_DONE); n_fail++;
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    cmd = mk_cmd(e_lce_cmd_sync, 3'd0, 2'd0, 32'h40, '0); cmd_v = 1'b1; resp_ready = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_DONE) begin
      $display("FAIL rmid_decode: got %h want %h", ctl, C_DONE); n_fail++;
    end
    @(negedge clk); #1;
    n_cmp++;
    if (ctl !== (C_RESPV | C_DONE)) begin
      $display("FAIL rmid_stall: got %h want %h", ctl, C_RESPV | C_DONE); n_fail++;
    end
    #1 reset_i = 1'b1;
    #1;
    n_cmp++;
    if (ctl !== 11'h000) begin
      $display("FAIL rmid_async: got %h want %h", ctl, 11'h000); n_fail++;
    end
    @(negedge clk);
    cmd_v = 1'b0;
    #1;
    n_cmp++;
    if (ctl !== C_READY) begin
      $display("FAIL rmid_held: got %h want %h", ctl, C_READY); n_fail++;
    end
    reset_i = 1'b0;
    @(negedge clk); #1;
    n_cmp++;
    if (ctl !== C_READY) begin
      $display("FAIL rmid_release: got %h want %h", ctl, C_READY); n_fail++;
    end
  endtask

  initial begin
    test_reset;
    test_sync;
    test_data;
    test_wakeup;
    test_uc_data;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
